posi_ref_fetch: RTL and testbench

- Read-side controller for the post-intra line/column/frame reference memories.
- Per request, fetches top + top-right words from the row RAM or the frame line RAM, then left + bottom-left words from the column RAM.
- Streams the fetched words to the post-intra datapath over a valid/ready interface.
- Drives the read ports of the post-intra memory wrapper directly; 1-cycle RAM read latency.

---
 rtl/posi_ref_fetch.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_posi_ref_fetch.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posi_ref_fetch.sv
// rtl/posi_ref_fetch.sv - post-intra reference fetch controller (optional stall counter: POSI_REF_FETCH_STAT_EN)

module posi_ref_fetch #(
   parameter int PIX_W   = 8,
   parameter int PIC_X_W = 8,
   parameter int FIFO_D  = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start_i,
   input  logic [3:0]           blk_x_i,
   input  logic [3:0]           blk_y_i,
   input  logic [1:0]           size_i,
   input  logic [PIC_X_W-1:0]   lcu_x_i,
   input  logic                 top_fra_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 row_rd_ena_o,
   output logic [7:0]           row_rd_adr_o,
   input  logic [4*PIX_W-1:0]   row_rd_dat_i,
   output logic                 col_rd_ena_o,
   output logic [7:0]           col_rd_adr_o,
   input  logic [4*PIX_W-1:0]   col_rd_dat_i,
   output logic                 fra_rd_ena_o,
   output logic [PIC_X_W+3:0]   fra_rd_adr_o,
   input  logic [4*PIX_W-1:0]   fra_rd_dat_i,
   output logic                 out_val_o,
   input  logic                 out_rdy_i,
   output logic [4*PIX_W-1:0]   out_dat_o,
   output logic                 out_sel_o,
   output logic                 out_last_o
`ifdef POSI_REF_FETCH_STAT_EN
   ,
   output logic [15:0]          stall_cnt_o
`endif
);

   localparam int DW = 4*PIX_W;
   localparam int FW = PIC_X_W+4;

   localparam logic [1:0] SRC_ROW = 2'd0;
   localparam logic [1:0] SRC_COL = 2'd1;
   localparam logic [1:0] SRC_FRA = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_TOP   = 2'd1,
      S_LEFT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   // latched request
   logic [3:0]         r_blk_x;
   logic [3:0]         r_blk_y;
   logic [1:0]         r_size;
   logic [PIC_X_W-1:0] r_lcu_x;
   logic               r_top_fra;
   logic [4:0]         r_k;

   // read in flight (one RAM latency stage)
   logic               r_infl;
   logic [1:0]         r_infl_src;
   logic               r_infl_sel;
   logic               r_infl_last;

   // address hold registers
   logic [7:0]         r_row_adr;
   logic [7:0]         r_col_adr;
   logic [FW-1:0]      r_fra_adr;

   // two-entry output buffer
   logic [DW-1:0]      r_fifo_dat [0:1];
   logic [1:0]         r_fifo_sel;
   logic [1:0]         r_fifo_last;
   logic               r_wr_ptr;
   logic               r_rd_ptr;
   logic [1:0]         r_fifo_cnt;

   logic               w_start_acc;
   logic               w_issue;
   logic [4:0]         w_k_max;
   logic               w_k_last;
   logic               w_pop;
   logic               w_push;
   logic [2:0]         w_occ;
   logic               w_credit_ok;
   logic [5:0]         w_sum_x;
   logic [5:0]         w_sum_y;
   logic [3:0]         w_sat_x;
   logic [3:0]         w_sat_y;
   logic [7:0]         w_row_adr_c;
   logic [7:0]         w_col_adr_c;
   logic [FW-1:0]      w_fra_adr_c;
   logic               w_row_iss;
   logic               w_col_iss;
   logic               w_fra_iss;
   logic [DW-1:0]      w_cap_dat;

   assign w_start_acc = (r_state == S_IDLE) && start_i;
   assign w_k_max     = (5'd2 << r_size) - 5'd1;
   assign w_k_last    = (r_k == w_k_max);

   assign out_val_o   = (r_fifo_cnt != 2'd0);
   assign out_dat_o   = r_fifo_dat[r_rd_ptr];
   assign out_sel_o   = r_fifo_sel[r_rd_ptr];
   assign out_last_o  = r_fifo_last[r_rd_ptr];

   assign w_pop       = out_val_o && out_rdy_i;
   assign w_push      = r_infl;

   // a word leaving this cycle frees its slot, which keeps streaming bubble-free
   assign w_occ       = {1'b0, r_fifo_cnt} + {2'b00, r_infl} - {2'b00, w_pop};
   assign w_credit_ok = (w_occ < 3'(FIFO_D));

   // neighbour words past the LCU edge repeat word 15
   assign w_sum_x     = {2'b00, r_blk_x} + {1'b0, r_k};
   assign w_sum_y     = {2'b00, r_blk_y} + {1'b0, r_k};
   assign w_sat_x     = (w_sum_x > 6'd15) ? 4'hF : w_sum_x[3:0];
   assign w_sat_y     = (w_sum_y > 6'd15) ? 4'hF : w_sum_y[3:0];
   assign w_row_adr_c = {r_blk_y, w_sat_x};
   assign w_col_adr_c = {r_blk_x, w_sat_y};
   // frame line is linear across LCUs, so carrying into the next segment is wanted
   assign w_fra_adr_c = {r_lcu_x, 4'b0000} + FW'(r_blk_x) + FW'(r_k);

   assign w_row_iss   = w_issue && (r_state == S_TOP) && !r_top_fra;
   assign w_fra_iss   = w_issue && (r_state == S_TOP) &&  r_top_fra;
   assign w_col_iss   = w_issue && (r_state == S_LEFT);

   assign row_rd_ena_o = w_row_iss;
   assign col_rd_ena_o = w_col_iss;
   assign fra_rd_ena_o = w_fra_iss;
   assign row_rd_adr_o = w_row_iss ? w_row_adr_c : r_row_adr;
   assign col_rd_adr_o = w_col_iss ? w_col_adr_c : r_col_adr;
   assign fra_rd_adr_o = w_fra_iss ? w_fra_adr_c : r_fra_adr;

   assign busy_o = (r_state != S_IDLE);

   // state register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state, read issue and completion pulse
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      done_o      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_nxt = S_TOP;
            end
         end
         S_TOP: begin
            w_issue = w_credit_ok;
            if (w_issue && w_k_last) begin
               w_state_nxt = S_LEFT;
            end
         end
         S_LEFT: begin
            w_issue = w_credit_ok;
            if (w_issue && w_k_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((r_fifo_cnt == 2'd0) && !r_infl) begin
               done_o      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // latch request fields at start and step the per-side read index
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_blk_x   <= 4'd0;
         r_blk_y   <= 4'd0;
         r_size    <= 2'd0;
         r_lcu_x   <= '0;
         r_top_fra <= 1'b0;
         r_k       <= 5'd0;
      end else if (w_start_acc) begin
         r_blk_x   <= blk_x_i;
         r_blk_y   <= blk_y_i;
         r_size    <= size_i;
         r_lcu_x   <= lcu_x_i;
         r_top_fra <= top_fra_i;
         r_k       <= 5'd0;
      end else if (w_issue) begin
         r_k <= w_k_last ? 5'd0 : r_k + 5'd1;
      end
   end

   // tag the outstanding read so its return is captured from the right port
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_infl      <= 1'b0;
         r_infl_src  <= SRC_ROW;
         r_infl_sel  <= 1'b0;
         r_infl_last <= 1'b0;
      end else begin
         r_infl <= w_issue;
         if (w_issue) begin
            r_infl_src  <= w_col_iss ? SRC_COL : (w_fra_iss ? SRC_FRA : SRC_ROW);
            r_infl_sel  <= (r_state == S_LEFT);
            r_infl_last <= (r_state == S_LEFT) && w_k_last;
         end
      end
   end

   // hold the last issued address on idle read cycles
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_row_adr <= 8'd0;
         r_col_adr <= 8'd0;
         r_fra_adr <= '0;
      end else begin
         if (w_row_iss) r_row_adr <= w_row_adr_c;
         if (w_col_iss) r_col_adr <= w_col_adr_c;
         if (w_fra_iss) r_fra_adr <= w_fra_adr_c;
      end
   end

   // select the returning RAM port
   always_comb begin
      w_cap_dat = row_rd_dat_i;
      case (r_infl_src)
         SRC_COL: w_cap_dat = col_rd_dat_i;
         SRC_FRA: w_cap_dat = fra_rd_dat_i;
         default: w_cap_dat = row_rd_dat_i;
      endcase
   end

   // output buffer: push on RAM return, pop on handshake
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_fifo_dat[0] <= '0;
         r_fifo_dat[1] <= '0;
         r_fifo_sel    <= 2'b00;
         r_fifo_last   <= 2'b00;
         r_wr_ptr      <= 1'b0;
         r_rd_ptr      <= 1'b0;
         r_fifo_cnt    <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo_dat[r_wr_ptr]  <= w_cap_dat;
            r_fifo_sel[r_wr_ptr]  <= r_infl_sel;
            r_fifo_last[r_wr_ptr] <= r_infl_last;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

`ifdef POSI_REF_FETCH_STAT_EN
   logic [15:0] r_stall_cnt;

   // count consumer back-pressure cycles within a request, saturating
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_stall_cnt <= 16'd0;
      end else if (w_start_acc) begin
         r_stall_cnt <= 16'd0;
      end else if (busy_o && out_val_o && !out_rdy_i && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_posi_ref_fetch.sv
// tb/tb_posi_ref_fetch.sv - directed self-checking bench for posi_ref_fetch

module tb_posi_ref_fetch;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start_i;
   logic [3:0]  blk_x_i;
   logic [3:0]  blk_y_i;
   logic [1:0]  size_i;
   logic [7:0]  lcu_x_i;
   logic        top_fra_i;
   logic        busy_o;
   logic        done_o;
   logic        row_rd_ena_o;
   logic [7:0]  row_rd_adr_o;
   logic [31:0] row_rd_dat_i;
   logic        col_rd_ena_o;
   logic [7:0]  col_rd_adr_o;
   logic [31:0] col_rd_dat_i;
   logic        fra_rd_ena_o;
   logic [11:0] fra_rd_adr_o;
   logic [31:0] fra_rd_dat_i;
   logic        out_val_o;
   logic        out_rdy_i;
   logic [31:0] out_dat_o;
   logic        out_sel_o;
   logic        out_last_o;
`ifdef POSI_REF_FETCH_STAT_EN
   logic [15:0] stall_cnt_o;
`endif

   posi_ref_fetch #(.PIX_W(8), .PIC_X_W(8), .FIFO_D(2)) dut (
      .clk(clk), .rstn(rstn), .start_i(start_i),
      .blk_x_i(blk_x_i), .blk_y_i(blk_y_i), .size_i(size_i),
      .lcu_x_i(lcu_x_i), .top_fra_i(top_fra_i),
      .busy_o(busy_o), .done_o(done_o),
      .row_rd_ena_o(row_rd_ena_o), .row_rd_adr_o(row_rd_adr_o), .row_rd_dat_i(row_rd_dat_i),
      .col_rd_ena_o(col_rd_ena_o), .col_rd_adr_o(col_rd_adr_o), .col_rd_dat_i(col_rd_dat_i),
      .fra_rd_ena_o(fra_rd_ena_o), .fra_rd_adr_o(fra_rd_adr_o), .fra_rd_dat_i(fra_rd_dat_i),
      .out_val_o(out_val_o), .out_rdy_i(out_rdy_i), .out_dat_o(out_dat_o),
      .out_sel_o(out_sel_o), .out_last_o(out_last_o)
`ifdef POSI_REF_FETCH_STAT_EN
      , .stall_cnt_o(stall_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit rdy_mode = 1'b0;

   logic [31:0] q_row[$];
   logic [31:0] q_col[$];
   logic [31:0] q_fra[$];
   logic [31:0] q_dat[$];
   logic        q_sel[$];
   logic        q_last[$];
   int          q_wcyc[$];
   int          q_done[$];
   int          multi_ena, hold_viol, max_out, n_iss, n_pop, stalls;
   logic        prev_stall;
   logic [31:0] prev_dat;
   logic        prev_sel, prev_last;

   always @(posedge clk) cyc++;

   // RAM models, one-cycle read latency, data tagged with source and address
   always @(posedge clk) begin
      if (row_rd_ena_o) row_rd_dat_i <= 32'h1000_0000 | 32'(row_rd_adr_o);
      if (col_rd_ena_o) col_rd_dat_i <= 32'h2000_0000 | 32'(col_rd_adr_o);
      if (fra_rd_ena_o) fra_rd_dat_i <= 32'h3000_0000 | 32'(fra_rd_adr_o);
   end

   always @(posedge clk) begin
      #1;
      out_rdy_i = rdy_mode ? (cyc % 3 == 0) : 1'b1;
   end

   // passive monitor sampled mid-cycle
   always @(negedge clk) begin
      if (!rstn) begin
         prev_stall = 1'b0;
      end else begin
         if (int'(row_rd_ena_o) + int'(col_rd_ena_o) + int'(fra_rd_ena_o) > 1) multi_ena++;
         if (row_rd_ena_o) q_row.push_back(32'(row_rd_adr_o));
         if (col_rd_ena_o) q_col.push_back(32'(col_rd_adr_o));
         if (fra_rd_ena_o) q_fra.push_back(32'(fra_rd_adr_o));
         n_iss += int'(row_rd_ena_o) + int'(col_rd_ena_o) + int'(fra_rd_ena_o);
         if (prev_stall && (!out_val_o || out_dat_o !== prev_dat ||
                            out_sel_o !== prev_sel || out_last_o !== prev_last)) hold_viol++;
         if (out_val_o && out_rdy_i) begin
            q_dat.push_back(out_dat_o);
            q_sel.push_back(out_sel_o);
            q_last.push_back(out_last_o);
            q_wcyc.push_back(cyc);
            n_pop++;
         end
         if (n_iss - n_pop > max_out) max_out = n_iss - n_pop;
         if (busy_o && out_val_o && !out_rdy_i) stalls++;
         prev_stall = out_val_o && !out_rdy_i;
         prev_dat   = out_dat_o;
         prev_sel   = out_sel_o;
         prev_last  = out_last_o;
         if (done_o) q_done.push_back(cyc);
      end
   end

   function automatic int sat15(int v);
      return (v > 15) ? 15 : v;
   endfunction

   function automatic logic [31:0] exp_word(int i, int sz, int bx, int by, int lcu, bit fra);
      int n2 = 2 << sz;
      if (i < n2) begin
         if (fra) return 32'h3000_0000 | 32'((lcu*16 + bx + i) % 4096);
         return 32'h1000_0000 | 32'(by*16 + sat15(bx + i));
      end
      return 32'h2000_0000 | 32'(bx*16 + sat15(by + i - n2));
   endfunction

   task automatic clear_logs();
      q_row.delete(); q_col.delete(); q_fra.delete();
      q_dat.delete(); q_sel.delete(); q_last.delete(); q_wcyc.delete(); q_done.delete();
      multi_ena = 0; hold_viol = 0; max_out = 0; n_iss = 0; n_pop = 0; stalls = 0;
   endtask

   // call at posedge+1; returns at posedge+1 after the accepting edge, inputs scrambled
   task automatic do_request(input int sz, input int bx, input int by, input int lcu,
                             input bit fra, output int scyc);
      clear_logs();
      size_i = 2'(sz); blk_x_i = 4'(bx); blk_y_i = 4'(by); lcu_x_i = 8'(lcu); top_fra_i = fra;
      start_i = 1'b1;
      @(posedge clk); #1;
      scyc = cyc;
      start_i = 1'b0;
      size_i = ~size_i; blk_x_i = ~blk_x_i; blk_y_i = ~blk_y_i; lcu_x_i = ~lcu_x_i; top_fra_i = ~top_fra_i;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done_o) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; start_i = 1'b0; out_rdy_i = 1'b1;
      blk_x_i = 4'd0; blk_y_i = 4'd0; size_i = 2'd0; lcu_x_i = 8'd0; top_fra_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy_o, done_o, row_rd_ena_o, col_rd_ena_o, fra_rd_ena_o, out_val_o, out_sel_o, out_last_o} !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_ctrl: got %b expected 00000000",
                  {busy_o, done_o, row_rd_ena_o, col_rd_ena_o, fra_rd_ena_o, out_val_o, out_sel_o, out_last_o});
      end
      n_checks++;
      if ({row_rd_adr_o, col_rd_adr_o, fra_rd_adr_o, out_dat_o} !== 60'h0) begin
         n_errors++;
         $display("FAIL reset_data: got %h expected 0", {row_rd_adr_o, col_rd_adr_o, fra_rd_adr_o, out_dat_o});
      end
      rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int  scyc;
      bit  ok;
      logic [31:0] e_row [2] = '{32'h53, 32'h54};
      logic [31:0] e_col [2] = '{32'h35, 32'h36};
      logic [31:0] e_dat [4] = '{32'h1000_0053, 32'h1000_0054, 32'h2000_0035, 32'h2000_0036};
      do_request(0, 3, 5, 0, 1'b0, scyc);
      wait_done(ok);
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL basic_done_timeout: got none expected done_o"); end
      n_checks++;
      if (q_row.size() != 2 || q_col.size() != 2 || q_fra.size() != 0 || q_dat.size() != 4) begin
         n_errors++;
         $display("FAIL basic_counts: got row=%0d col=%0d fra=%0d words=%0d expected 2 2 0 4",
                  q_row.size(), q_col.size(), q_fra.size(), q_dat.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (q_row[i] !== e_row[i] || q_col[i] !== e_col[i]) begin
               n_errors++;
               $display("FAIL basic_adr[%0d]: got row=%h col=%h expected %h %h", i, q_row[i], q_col[i], e_row[i], e_col[i]);
            end
         end
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (q_dat[i] !== e_dat[i] || q_sel[i] !== (i >= 2) || q_last[i] !== (i == 3) || q_wcyc[i] != scyc + 2 + i) begin
               n_errors++;
               $display("FAIL basic_word[%0d]: got dat=%h sel=%b last=%b cyc=%0d expected %h %b %b %0d",
                        i, q_dat[i], q_sel[i], q_last[i], q_wcyc[i] - scyc, e_dat[i], (i >= 2), (i == 3), 2 + i);
            end
         end
      end
      n_checks++;
      if (q_done.size() != 1 || q_done[0] != scyc + 6) begin
         n_errors++;
         $display("FAIL basic_done_cycle: got count=%0d cyc=%0d expected 1 at 6",
                  q_done.size(), (q_done.size() > 0) ? q_done[0] - scyc : -1);
      end
      n_checks++;
      if (multi_ena != 0) begin n_errors++; $display("FAIL basic_one_ena: got %0d multi-enable cycles expected 0", multi_ena); end
   endtask

   task automatic test_frame();
      int  scyc;
      bit  ok;
      logic [31:0] e;
      do_request(3, 14, 9, 5, 1'b1, scyc);
      wait_done(ok);
      n_checks++;
      if (!ok || q_fra.size() != 16 || q_col.size() != 16 || q_row.size() != 0 || q_dat.size() != 32) begin
         n_errors++;
         $display("FAIL frame_counts: got done=%b fra=%0d col=%0d row=%0d words=%0d expected 1 16 16 0 32",
                  ok, q_fra.size(), q_col.size(), q_row.size(), q_dat.size());
      end else begin
         for (int k = 0; k < 16; k++) begin
            e = (9 + k > 15) ? 32'hEF : 32'hE9 + 32'(k);
            n_checks++;
            if (q_fra[k] !== 32'(94 + k) || q_col[k] !== e) begin
               n_errors++;
               $display("FAIL frame_adr[%0d]: got fra=%0d col=%h expected %0d %h", k, q_fra[k], q_col[k], 94 + k, e);
            end
         end
         for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (q_dat[i] !== exp_word(i, 3, 14, 9, 5, 1'b1) || q_sel[i] !== (i >= 16) || q_last[i] !== (i == 31)) begin
               n_errors++;
               $display("FAIL frame_word[%0d]: got %h sel=%b last=%b expected %h", i, q_dat[i], q_sel[i], q_last[i],
                        exp_word(i, 3, 14, 9, 5, 1'b1));
            end
         end
      end
   endtask

   task automatic test_saturate();
      int  scyc;
      bit  ok;
      logic [31:0] e_adr [8] = '{32'hCC, 32'hCD, 32'hCE, 32'hCF, 32'hCF, 32'hCF, 32'hCF, 32'hCF};
      do_request(2, 12, 12, 0, 1'b0, scyc);
      wait_done(ok);
      n_checks++;
      if (!ok || q_row.size() != 8 || q_col.size() != 8) begin
         n_errors++;
         $display("FAIL sat_counts: got done=%b row=%0d col=%0d expected 1 8 8", ok, q_row.size(), q_col.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (q_row[k] !== e_adr[k] || q_col[k] !== e_adr[k]) begin
               n_errors++;
               $display("FAIL sat_adr[%0d]: got row=%h col=%h expected %h", k, q_row[k], q_col[k], e_adr[k]);
            end
         end
      end
   endtask

   task automatic test_stall();
      int  scyc;
      bit  ok;
      rdy_mode = 1'b1;
      do_request(1, 6, 1, 33, 1'b1, scyc);
      wait_done(ok);
      rdy_mode = 1'b0;
      n_checks++;
      if (!ok || q_dat.size() != 8) begin
         n_errors++;
         $display("FAIL stall_count: got done=%b words=%0d expected 1 8", ok, q_dat.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (q_dat[i] !== exp_word(i, 1, 6, 1, 33, 1'b1) || q_last[i] !== (i == 7)) begin
               n_errors++;
               $display("FAIL stall_word[%0d]: got %h last=%b expected %h", i, q_dat[i], q_last[i], exp_word(i, 1, 6, 1, 33, 1'b1));
            end
         end
      end
      n_checks++;
      if (hold_viol != 0 || stalls == 0) begin
         n_errors++;
         $display("FAIL stall_hold: got violations=%0d stalls=%0d expected 0 and >0", hold_viol, stalls);
      end
      n_checks++;
      if (max_out > 2) begin n_errors++; $display("FAIL stall_inflight: got %0d expected <=2", max_out); end
`ifdef POSI_REF_FETCH_STAT_EN
      n_checks++;
      if (stall_cnt_o !== 16'(stalls)) begin
         n_errors++;
         $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt_o, stalls);
      end
`endif
   endtask

   task automatic test_start_ignored();
      int  scyc;
      bit  ok;
      do_request(1, 2, 3, 0, 1'b0, scyc);
      repeat (2) begin @(posedge clk); #1; end
      size_i = 2'd3; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      wait_done(ok);
      repeat (4) begin @(posedge clk); #1; end
      n_checks++;
      if (!ok || q_dat.size() != 8 || q_done.size() != 1 || busy_o !== 1'b0) begin
         n_errors++;
         $display("FAIL busy_start: got done=%b words=%0d dones=%0d busy=%b expected 1 8 1 0",
                  ok, q_dat.size(), q_done.size(), busy_o);
      end
   endtask

   task automatic test_reset_mid();
      int  scyc;
      bit  ok;
      bit  seen = 1'b0;
      do_request(2, 4, 4, 0, 1'b0, scyc);
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = col_rd_ena_o;
      end
      @(posedge clk); #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (!seen || {busy_o, done_o, row_rd_ena_o, col_rd_ena_o, fra_rd_ena_o, out_val_o, out_sel_o, out_last_o} !== 8'h00
          || {row_rd_adr_o, col_rd_adr_o, fra_rd_adr_o, out_dat_o} !== 60'h0 || q_done.size() != 0) begin
         n_errors++;
         $display("FAIL midreset_outputs: got seen=%b ctrl=%b busy=%b dones=%0d expected 1 0 0 0", seen,
                  {row_rd_ena_o, col_rd_ena_o, fra_rd_ena_o, out_val_o}, busy_o, q_done.size());
      end
      rstn = 1'b1;
      @(posedge clk); #1;
      do_request(0, 1, 2, 0, 1'b0, scyc);
      wait_done(ok);
      n_checks++;
      if (!ok || q_dat.size() != 4 || q_dat[0] !== 32'h1000_0021 || q_dat[3] !== 32'h2000_0013 || q_last[3] !== 1'b1) begin
         n_errors++;
         $display("FAIL midreset_recover: got done=%b words=%0d first=%h expected 1 4 10000021",
                  ok, q_dat.size(), (q_dat.size() > 0) ? q_dat[0] : 32'h0);
      end
   endtask

   task automatic test_back_to_back();
      int  scyc_a, scyc_b, done_a;
      bit  ok;
      do_request(0, 0, 0, 0, 1'b0, scyc_a);
      wait_done(ok);
      done_a = (q_done.size() > 0) ? q_done[0] : -100;
      do_request(1, 8, 2, 0, 1'b0, scyc_b);
      wait_done(ok);
      n_checks++;
      if (!ok || scyc_b != done_a + 2 || q_dat.size() != 8) begin
         n_errors++;
         $display("FAIL b2b_accept: got done=%b start_gap=%0d words=%0d expected 1 2 8", ok, scyc_b - done_a, q_dat.size());
      end else begin
         n_checks++;
         if (q_dat[0] !== exp_word(0, 1, 8, 2, 0, 1'b0) || q_sel[0] !== 1'b0 || q_dat[7] !== exp_word(7, 1, 8, 2, 0, 1'b0)) begin
            n_errors++;
            $display("FAIL b2b_first: got %h sel=%b expected %h sel=0", q_dat[0], q_sel[0], exp_word(0, 1, 8, 2, 0, 1'b0));
         end
      end
   endtask

   initial begin
      clear_logs();
      test_reset();
      test_basic();
      test_frame();
      test_saturate();
      test_stall();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
